// File: rtl/wb_b3_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and the RAM slave.
interface wb_b3_burst_master_if #(
    parameter int unsigned aw = 25,
    parameter int unsigned dw = 32
);
    logic [aw-1:0] wb_adr_o;
    logic [dw-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [dw-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_b3_burst_master.sv
// Command-driven Wishbone B3 master: turns (address, length, direction) into
// an incrementing linear burst (classic cycle for single beats), with a
// valid/ready write-data stream in and a valid-only read-data stream out.
module wb_b3_burst_master #(
    parameter int unsigned aw = 25,
    parameter int unsigned dw = 32,
    parameter int unsigned lw = 5
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [aw-1:0]        cmd_adr,
    input  logic                 cmd_we,
    input  logic [lw-1:0]        cmd_len,
    input  logic                 wr_valid,
    input  logic [dw-1:0]        wr_data,
    output logic                 wr_ready,
    output logic                 rd_valid,
    output logic [dw-1:0]        rd_data,
    output logic                 rd_last,
    output logic                 done,
    output logic                 done_err,
    wb_b3_burst_master_if.master wb
);
    // Beat index / (length-1) fit in one bit less than the length field (1..16).
    localparam int unsigned bw = lw - 1;

    localparam logic [2:0] cti_classic = 3'b000;
    localparam logic [2:0] cti_incr    = 3'b010;
    localparam logic [2:0] cti_end     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] adr_q, adr_d;
    logic [bw-1:0] len_m1_q, len_m1_d;
    logic [bw-1:0] beat_q, beat_d;
    logic          we_q, we_d;
    logic          err_q, err_d;

    logic [bw-1:0] cmd_len_m1;
    logic          cmd_fire;
    logic          in_bus;
    logic          last_beat;
    logic          stb;
    logic          ack_hit;
    logic          err_hit;

    // Retry is never driven by the RAM slave; the address LSBs are word-aligned away.
    logic unused_ok;
    assign unused_ok = ^{wb.wb_rty_i, cmd_adr[1:0]};

    // A zero length is executed as a single beat.
    assign cmd_len_m1 = (cmd_len == '0) ? '0 : bw'(cmd_len - lw'(1));

    // Command acceptance is open in IDLE and in the DONE cycle, closed during reset.
    assign cmd_ready = !wb_rst_i && (state_q != S_BUS);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Bus qualifiers; an error on the same cycle as an ack takes precedence.
    assign in_bus    = (state_q == S_BUS);
    assign last_beat = (beat_q == len_m1_q);
    assign stb       = in_bus && (we_q ? wr_valid : 1'b1);
    assign err_hit   = stb && wb.wb_err_i;
    assign ack_hit   = stb && wb.wb_ack_i && !wb.wb_err_i;

    // State and command-context registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            len_m1_q <= '0;
            beat_q   <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            len_m1_q <= len_m1_d;
            beat_q   <= beat_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    // Next-state: accept, advance on ack, finish on last ack or on error.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        len_m1_d = len_m1_q;
        beat_d   = beat_q;
        we_d     = we_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (cmd_fire) begin
                    adr_d    = {cmd_adr[aw-1:2], 2'b00};
                    len_m1_d = cmd_len_m1;
                    beat_d   = '0;
                    we_d     = cmd_we;
                    err_d    = 1'b0;
                    state_d  = S_BUS;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                if (err_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (ack_hit) begin
                    beat_d = beat_q + bw'(1);
                    adr_d  = adr_q + aw'(4);
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wishbone outputs; cti is derived from registered beat/length so it only moves after an ack.
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = wr_data;
    assign wb.wb_sel_o = 4'hf;
    assign wb.wb_bte_o = 2'b00;
    assign wb.wb_cyc_o = in_bus;
    assign wb.wb_stb_o = stb;
    assign wb.wb_we_o  = in_bus && we_q;
    assign wb.wb_cti_o = !in_bus              ? cti_classic :
                         (len_m1_q == '0)     ? cti_classic :
                         last_beat            ? cti_end     : cti_incr;

    // Stream side: write beats consumed and read beats delivered on accepted acks only.
    assign wr_ready = ack_hit && we_q;
    assign rd_valid = ack_hit && !we_q;
    assign rd_data  = wb.wb_dat_i;
    assign rd_last  = rd_valid && last_beat;

    // Completion pulse, qualified by the abort flag.
    assign done     = (state_q == S_DONE);
    assign done_err = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Scoreboard bench for wb_b3_burst_master with a registered-feedback RAM slave.
module tb_wb_b3_burst_master;
    localparam int unsigned AW = 25;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 5;
    localparam int unsigned RAM_WORDS = 1024;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_adr = '0;
    logic          cmd_we = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          done;
    logic          done_err;

    wb_b3_burst_master_if #(.aw(AW), .dw(DW)) wb ();

    wb_b3_burst_master #(.aw(AW), .dw(DW), .lw(LW)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_adr   (cmd_adr),
        .cmd_we    (cmd_we),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .done_err  (done_err),
        .wb        (wb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [AW-1:0] adr;
        logic [2:0]    cti;
        logic          we;
        logic [31:0]   wdata;
        logic          is_err;
        logic          fin;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rd_t;

    typedef struct {
        logic [31:0] data;
        int          gap;
    } wr_t;

    beat_t bus_q[$];
    rd_t   rd_q[$];
    logic  done_q[$];
    wr_t   wr_q[$];
    int    err_q[$];

    logic [31:0] ram     [RAM_WORDS];
    logic [31:0] ref_mem [RAM_WORDS];

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not expected or not seen at %0t", name, $time);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h40) return 32'hDEAD_BEEF;
        return 32'h1234_5678 ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // ---------------- RAM slave (registered feedback, drops ack at end of burst)
    logic slv_ack = 1'b0;
    logic slv_prev_cyc = 1'b0;
    int   slv_cnt = 0;
    int   slv_err_at = -1;

    assign wb.wb_dat_i = ram[wb.wb_adr_o[11:2]];
    assign wb.wb_ack_i = slv_ack;
    assign wb.wb_err_i = slv_ack && wb.wb_stb_o && (slv_cnt == slv_err_at);
    assign wb.wb_rty_i = 1'b0;

    initial begin : slave
        for (int i = 0; i < int'(RAM_WORDS); i++) ram[i] = init_word(i);
        forever begin
            @(posedge wb_clk_i);
            if (wb.wb_cyc_o && !slv_prev_cyc)
                slv_err_at <= (err_q.size() > 0) ? err_q.pop_front() : -1;
            slv_ack <= wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_err_i &&
                       !(slv_ack && (wb.wb_cti_o == 3'b000 || wb.wb_cti_o == 3'b111));
            if (!wb.wb_cyc_o) slv_cnt <= 0;
            else if (wb.wb_stb_o && slv_ack && !wb.wb_err_i) slv_cnt <= slv_cnt + 1;
            if (wb.wb_cyc_o && wb.wb_stb_o && slv_ack && !wb.wb_err_i && wb.wb_we_o)
                ram[wb.wb_adr_o[11:2]] <= wb.wb_dat_o;
            slv_prev_cyc <= wb.wb_cyc_o;
        end
    end

    // ---------------- write-data source with per-word leading gaps
    initial begin : feeder
        logic started;
        int   gap_left;
        started = 1'b0;
        gap_left = 0;
        forever begin
            @(negedge wb_clk_i);
            if (wr_q.size() == 0) begin
                wr_valid = 1'b0;
            end else begin
                if (!started) begin
                    gap_left = wr_q[0].gap;
                    started = 1'b1;
                end
                if (gap_left > 0) begin
                    wr_valid = 1'b0;
                    gap_left--;
                end else begin
                    wr_valid = 1'b1;
                    wr_data = wr_q[0].data;
                end
            end
            #1;
            if (wr_valid && (wr_ready || (wb.wb_err_i && wb.wb_stb_o && wb.wb_we_o))) begin
                wr_q.delete(0);
                started = 1'b0;
            end
        end
    end

    // ---------------- monitor: bus beats, read stream, completion
    initial begin : monitor
        logic  exp_done;
        beat_t b;
        exp_done = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            #1;
            if (wb_rst_i) begin
                exp_done = 1'b0;
            end else begin
                if (done || exp_done) begin
                    check("done_timing", done, exp_done);
                    if (done) begin
                        check("done_cyc_low", wb.wb_cyc_o, 1'b0);
                        check("done_cmd_ready", cmd_ready, 1'b1);
                        if (done_q.size() > 0) begin
                            check("done_err", done_err, done_q[0]);
                            done_q.delete(0);
                        end else fail("done_unexpected");
                    end
                end else if (done_err) begin
                    check("done_err_unqualified", done_err, 1'b0);
                end
                exp_done = 1'b0;

                if (wb.wb_cyc_o) begin
                    if (bus_q.size() == 0) fail("cyc_unexpected");
                    else begin
                        b = bus_q[0];
                        check("adr", wb.wb_adr_o, b.adr);
                        check("cti", wb.wb_cti_o, b.cti);
                        check("we", wb.wb_we_o, b.we);
                        check("sel", wb.wb_sel_o, 4'hf);
                        check("bte", wb.wb_bte_o, 2'b00);
                        check("stb", wb.wb_stb_o, b.we ? wr_valid : 1'b1);
                        if (wb.wb_stb_o && wb.wb_err_i) begin
                            check("err_on_expected_beat", b.is_err, 1'b1);
                            check("err_no_rd_valid", rd_valid, 1'b0);
                            check("err_no_wr_ready", wr_ready, 1'b0);
                            exp_done = b.fin;
                            bus_q.delete(0);
                        end else if (wb.wb_stb_o && wb.wb_ack_i) begin
                            check("ack_on_err_beat", b.is_err, 1'b0);
                            if (b.we) check("wdat", wb.wb_dat_o, b.wdata);
                            check("wr_ready", wr_ready, b.we);
                            exp_done = b.fin;
                            bus_q.delete(0);
                        end
                    end
                end

                if (rd_valid) begin
                    if (rd_q.size() == 0) fail("rd_valid_unexpected");
                    else begin
                        check("rd_data", rd_data, rd_q[0].data);
                        check("rd_last", rd_last, rd_q[0].last);
                        rd_q.delete(0);
                    end
                end else if (rd_last) begin
                    check("rd_last_without_valid", rd_last, 1'b0);
                end
            end
        end
    end

    // ---------------- reference model + command driver
    // gap_at = -2 selects random gaps on every write word.
    task automatic issue(input logic [AW-1:0] adr, input int len, input logic we,
                         input int err_at, input int gap_at, input int gap_len);
        int            n;
        int            nb;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        beat_t         b;
        rd_t           r;
        wr_t           w;
        n    = (len == 0) ? 1 : len;
        nb   = (err_at >= 0) ? err_at + 1 : n;
        base = {adr[AW-1:2], 2'b00};
        for (int i = 0; i < nb; i++) begin
            a        = AW'(base + AW'(4 * i));
            b.adr    = a;
            b.cti    = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
            b.we     = we;
            b.wdata  = we ? $urandom : 32'h0;
            b.is_err = (i == err_at);
            b.fin    = (i == err_at) || (i == n - 1);
            if (we) begin
                w.data = b.wdata;
                w.gap  = (gap_at == -2) ? int'($urandom_range(0, 2)) : ((i == gap_at) ? gap_len : 0);
                wr_q.push_back(w);
            end
            if (!b.is_err) begin
                if (we) ref_mem[a[11:2]] = b.wdata;
                else begin
                    r.data = ref_mem[a[11:2]];
                    r.last = (i == n - 1);
                    rd_q.push_back(r);
                end
            end
            bus_q.push_back(b);
        end
        done_q.push_back(err_at >= 0);
        err_q.push_back(err_at);

        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_adr   = adr;
        cmd_we    = we;
        cmd_len   = LW'(len);
        begin : hs
            for (int t = 0; t < 500; t++) begin
                #1;
                if (cmd_ready) disable hs;
                @(negedge wb_clk_i);
            end
            fail("cmd_accept_timeout");
        end
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        begin : wl
            for (int t = 0; t < 3000; t++) begin
                @(negedge wb_clk_i);
                #2;
                if (bus_q.size() == 0 && rd_q.size() == 0 && done_q.size() == 0 &&
                    wr_q.size() == 0 && !wb.wb_cyc_o) disable wl;
            end
            fail("drain_timeout");
        end
        @(negedge wb_clk_i);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int mism;
        for (int i = 0; i < int'(RAM_WORDS); i++) ref_mem[i] = init_word(i);

        // reset state
        repeat (3) @(negedge wb_clk_i);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_cyc", wb.wb_cyc_o, 1'b0);
        check("rst_stb", wb.wb_stb_o, 1'b0);
        check("rst_we", wb.wb_we_o, 1'b0);
        check("rst_cti", wb.wb_cti_o, 3'b000);
        check("rst_adr", wb.wb_adr_o, '0);
        check("rst_done", done, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // single classic read of the preloaded word
        issue(AW'(32'h100), 1, 1'b0, -1, -1, 0);
        wait_idle();

        // 8-beat read burst
        issue(AW'(32'h200), 8, 1'b0, -1, -1, 0);
        wait_idle();

        // 4-beat write with a two-cycle gap before beat 3
        issue(AW'(32'h40), 4, 1'b1, -1, 2, 2);
        wait_idle();
        for (int i = 0; i < 4; i++) check("wr_burst_mem", ram[16 + i], ref_mem[16 + i]);

        // error on beat 3 of a 6-beat read, then an error-aborted write
        issue(AW'(32'h300), 6, 1'b0, 2, -1, 0);
        wait_idle();
        issue(AW'(32'h380), 5, 1'b1, 3, -1, 0);
        wait_idle();

        // address wrap at the top of the space, read and write
        issue(AW'(32'h1FF_FFF8), 4, 1'b0, -1, -1, 0);
        wait_idle();
        issue(AW'(32'h1FF_FFF8), 4, 1'b1, -1, -1, 0);
        wait_idle();

        // zero length behaves as one beat
        issue(AW'(32'h504), 0, 1'b0, -1, -1, 0);
        wait_idle();

        // asynchronous reset during beat 2 of a 4-beat read
        issue(AW'(32'h400), 4, 1'b0, -1, -1, 0);
        begin : wr1
            for (int t = 0; t < 50; t++) begin
                #1;
                if (rd_valid) disable wr1;
                @(negedge wb_clk_i);
            end
            fail("first_beat_timeout");
        end
        @(negedge wb_clk_i);
        #3;
        wb_rst_i = 1'b1;
        #1;
        check("async_rst_cyc", wb.wb_cyc_o, 1'b0);
        check("async_rst_stb", wb.wb_stb_o, 1'b0);
        check("async_rst_cmd_ready", cmd_ready, 1'b0);
        check("async_rst_done", done, 1'b0);
        bus_q.delete();
        rd_q.delete();
        done_q.delete();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        check("post_rst_no_done", done, 1'b0);
        issue(AW'(32'h480), 2, 1'b0, -1, -1, 0);
        wait_idle();

        // randomized commands, some back-to-back, some aborted
        for (int k = 0; k < 30; k++) begin
            int   len;
            int   n;
            int   ea;
            logic we;
            len = int'($urandom_range(0, 16));
            n   = (len == 0) ? 1 : len;
            we  = 1'($urandom_range(0, 1));
            ea  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            issue(AW'($urandom), len, we, ea, -2, 0);
            repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
        end
        wait_idle();

        mism = 0;
        for (int i = 0; i < int'(RAM_WORDS); i++) if (ram[i] !== ref_mem[i]) mism++;
        check("ram_final_mismatches", 64'(mism), 64'd0);
        check("leftover_beats", 64'(bus_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_b3_burst_master.md
Name: wb_b3_burst_master

Overview:
- Command-driven Wishbone B3 master that sits directly upstream of the on-chip Wishbone RAM slave.
- Converts one command (byte address, beat count, direction) into a registered-feedback incrementing linear burst: cti 010 … 111, bte 00.
- Single-beat commands are issued as classic cycles (cti 000).
- Write data enters on a valid/ready stream; read data leaves on a valid-only stream.

Parameters:
- aw, 25: Wishbone byte-address width.
- dw, 32: data width; fixed at 32, with a 4-bit select.
- lw, 5: beat-count width. Legal lengths are 1..16.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_adr  in  aw  start byte address; bits [1:0] are ignored.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_len  in  lw  beat count, 1..16. A value of 0 is treated as 1.
- wr_valid  in  1  write data available.
- wr_data  in  dw  write data.
- wr_ready  out  1  write beat consumed.
- rd_valid  out  1  read beat valid; single-cycle pulse, no backpressure.
- rd_data  out  dw  read data.
- rd_last  out  1  marks the final read beat.
- done  out  1  one-cycle pulse when a command completes.
- done_err  out  1  qualifies done: 1 if the command was aborted by wb_err_i.
- wb_adr_o  out  aw  Wishbone address.
- wb_dat_o  out  dw  Wishbone write data.
- wb_sel_o  out  4  byte select, constant 4'hf.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cti_o  out  3  cycle type identifier.
- wb_bte_o  out  2  burst type extension, constant 2'b00.
- wb_dat_i  in  dw  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_rty_i  in  1  Wishbone retry; ignored (the slave ties it to 0).

Behaviour:
- Reset (asynchronous) forces the following, immediately, including mid-burst with no completion:
  - state = IDLE;
  - wb_cyc_o = wb_stb_o = wb_we_o = 0, wb_cti_o = 000, wb_adr_o = 0;
  - cmd_ready = 0 while reset is asserted, then 1 from the first cycle in IDLE;
  - done = done_err = rd_valid = rd_last = wr_ready = 0.
- State IDLE:
  - cmd_ready = 1.
  - On handshake: latch adr = {cmd_adr[aw-1:2], 2'b00}, len, we; clear beat counter; go to BUS.
  - First wb_cyc_o occurs the cycle after the handshake, so command-to-cyc latency is 1.
- State BUS, outputs:
  - wb_cyc_o = 1 (registered).
  - wb_stb_o = cyc & (we ? wr_valid : 1). This is the only combinational path to stb. While wr_valid is low the master inserts wait states: stb = 0, cyc stays 1, address and cti are held.
  - wb_dat_o = wr_data; wr_ready = we & wb_ack_i.
  - rd_valid = !we & wb_ack_i; rd_data = wb_dat_i; rd_last = rd_valid & (beat == len-1).
- wb_cti_o:
  - 000 if len == 1;
  - otherwise 010 while beat < len-1, and 111 on beat == len-1.
  - cti changes only after an ack.
- On each wb_ack_i with stb high:
  - beat increments;
  - wb_adr_o advances by 4 on the next cycle, with wrap-around modulo 2^aw.
  - Acks arriving while stb = 0 are ignored.
- Ack on the last beat:
  - go to DONE; wb_cyc_o and wb_stb_o are 0 the next cycle;
  - done = 1 in that cycle, then return to IDLE.
  - Each command therefore has exactly one cycle of idle bus between commands, which lets the slave drop its end-of-burst ack.
- wb_err_i with stb high:
  - the current beat is not counted and no rd_valid/wr_ready is produced;
  - go to DONE with done_err = 1, aborting the rest of the burst.
- wb_err_i and wb_ack_i in the same cycle: err wins.
- A back-to-back command may be accepted in the cycle done is high, since cmd_ready = 1 in DONE. cyc then re-asserts the following cycle.
- Read beats: the bench and consumer must accept every rd_valid; no stall is possible.

Test Plan:
- Single read: cmd_adr = 0x100, len = 1, we = 0, against the RAM preloaded mem[0x40] = 0xDEADBEEF
  -> cti = 000, one stb, rd_valid with 0xDEADBEEF, rd_last = 1, done the cycle after the ack.
- Read burst: adr = 0x200, len = 8 against the RAM
  -> adr 0x200..0x21C, cti 010 ×7 then 111, eight rd_valid beats in consecutive cycles after the first ack, rd_last on beat 8.
- Write burst with gaps: adr = 0x40, len = 4, wr_valid low for 2 cycles before beat 3
  -> stb = 0 for those cycles with adr = 0x48 and cti = 010 held; memory holds all 4 words at 0x40..0x4C afterwards; done = 1, done_err = 0.
- Error abort: slave model asserts wb_err_i on beat 3 of a len = 6 read
  -> 2 rd_valid pulses, cyc drops the next cycle, done = 1 with done_err = 1.
- Address wrap: adr = 2^aw − 8, len = 4
  -> addresses run top−8, top−4, 0x0, 0x4.
- Reset mid-burst, asserted asynchronously during beat 2 of 4
  -> cyc/stb = 0 immediately, no done; after release, cmd_ready = 1 and a new len = 2 burst completes correctly.
